// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo family: address-width calculation and
// parameter legality check used at elaboration time.
package fifo_pkg;

  // Ceiling log2 of the depth; gives the memory index width.
  function automatic int fifo_addr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  // Returns 1 when depth is a power of two >= 2 and both thresholds are in range.
  function automatic bit fifo_params_ok(input int depth, input int af_level, input int ae_level);
    bit pow2;
    pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return pow2 && (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Producer/consumer bundle for fifo_sync.
//
// Handshake: a word on data_in is taken at a rising clock edge when
// data_in_valid=1 and data_in_full=0 (data_in_full acts as the inverted
// ready). The head word on data_out is consumed at a rising edge when
// data_out_valid=1 and data_out_ack=1; data_out is presented without any
// read request (first-word-fall-through). An ack while data_out_valid=0 is
// not a transfer and is reported on the sticky underflow flag; a write while
// full is dropped and reported on the sticky overflow flag.
interface fifo_sync_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUFFER_SIZE = 16
);
  import fifo_pkg::*;

  localparam int LW = fifo_addr_width(BUFFER_SIZE) + 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_full;
  logic                  data_in_almost_full;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ack;
  logic                  data_out_almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;

  // FIFO side.
  modport slave (
    input  data_in, data_in_valid, data_out_ack,
    output data_in_full, data_in_almost_full, data_out, data_out_valid,
           data_out_almost_empty, level, overflow, underflow
  );

  // Producer/consumer side.
  modport master (
    output data_in, data_in_valid, data_out_ack,
    input  data_in_full, data_in_almost_full, data_out, data_out_valid,
           data_out_almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Register-array storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: store wdata at waddr when we is high.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FWFT FIFO with registered level, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
// All status outputs derive from the registered level only.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int BUFFER_SIZE        = 16,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       flush,
  fifo_sync_if.slave bus
);

  localparam int AW = fifo_addr_width(BUFFER_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(BUFFER_SIZE);
  localparam logic [PW-1:0] AF_LVL   = PW'(ALMOST_FULL_LEVEL);
  localparam logic [PW-1:0] AE_LVL   = PW'(ALMOST_EMPTY_LEVEL);

  if (!fifo_params_ok(BUFFER_SIZE, ALMOST_FULL_LEVEL, ALMOST_EMPTY_LEVEL)) begin : g_param_error
    $error("fifo_sync: BUFFER_SIZE must be a power of two >= 2 and thresholds in range");
  end

  // Pointers carry one extra MSB so full and empty stay distinguishable;
  // they wrap naturally modulo 2*BUFFER_SIZE.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic                  is_full;
  logic                  is_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Transfer qualification from the pre-edge level; flush suppresses both sides.
  always_comb begin
    is_full  = (level_q == FULL_LVL);
    is_empty = (level_q == '0);
    push     = bus.data_in_valid & ~is_full & ~flush;
    pop      = bus.data_out_ack & ~is_empty & ~flush;
  end

  // Next-state for pointers, level and sticky flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};
      // A dropped write is flagged even when a pop frees space this same edge.
      if (bus.data_in_valid && is_full)  overflow_d  = 1'b1;
      if (bus.data_out_ack && is_empty)  underflow_d = 1'b1;
    end
  end

  // State registers; reset wins over flush and discards everything.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUFFER_SIZE),
    .AW         (AW)
  ) u_ram (
    .clk   (clock),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Status and gated head word, all from registered level.
  always_comb begin
    bus.data_in_full          = is_full;
    bus.data_in_almost_full   = (level_q >= AF_LVL);
    bus.data_out_valid        = ~is_empty;
    bus.data_out_almost_empty = (level_q <= AE_LVL);
    bus.data_out              = is_empty ? '0 : ram_rdata;
    bus.level                 = level_q;
    bus.overflow              = overflow_q;
    bus.underflow             = underflow_q;
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync with a queue-based reference model.
module tb_fifo_sync;

  localparam int DW = 32;
  localparam int BS = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic clock;
  logic rst;
  logic flush;

  fifo_sync_if #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS)) bus ();

  fifo_sync #(
    .DATA_WIDTH         (DW),
    .BUFFER_SIZE        (BS),
    .ALMOST_FULL_LEVEL  (AF),
    .ALMOST_EMPTY_LEVEL (AE)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: contents as a queue plus the two sticky flags.
  logic [DW-1:0] exp_q[$];
  bit            m_ovf;
  bit            m_unf;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_step(input logic v, input logic a, input logic [DW-1:0] d,
                                     input logic f, input logic r);
    bit was_full;
    bit was_empty;
    if (r || f) begin
      exp_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      was_full  = (exp_q.size() == BS);
      was_empty = (exp_q.size() == 0);
      if (v && was_full)  m_ovf = 1;
      if (a && was_empty) m_unf = 1;
      if (a && !was_empty) void'(exp_q.pop_front());
      if (v && !was_full)  exp_q.push_back(d);
    end
  endfunction

  // Drive one clock cycle of inputs, advance the model, settle past the edge.
  task automatic cycle(input logic v, input logic a, input logic [DW-1:0] d,
                       input logic f, input logic r);
    bus.data_in       = d;
    bus.data_in_valid = v;
    bus.data_out_ack  = a;
    flush             = f;
    rst               = r;
    @(posedge clock);
    model_step(v, a, d, f, r);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
    bus.data_in_valid = 1'b0;
    bus.data_out_ack  = 1'b0;
    flush             = 1'b0;
    rst               = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (bus.data_in_full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.data_in_full); else n_pass++;
      n_checks++; if (bus.data_in_almost_full !== 1'b0) $display("FAIL reset_af got %b want 0", bus.data_in_almost_full); else n_pass++;
      n_checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.data_out_valid); else n_pass++;
      n_checks++; if (bus.data_out !== 32'h0) $display("FAIL reset_dout got %h want 0", bus.data_out); else n_pass++;
      n_checks++; if (bus.data_out_almost_empty !== 1'b1) $display("FAIL reset_ae got %b want 1", bus.data_out_almost_empty); else n_pass++;
      n_checks++; if (bus.level !== 5'd0) $display("FAIL reset_level got %0d want 0", bus.level); else n_pass++;
      n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow); else n_pass++;
      n_checks++; if (bus.underflow !== 1'b0) $display("FAIL reset_unf got %b want 0", bus.underflow); else n_pass++;
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
      if (i == 11) begin
        n_checks++; if (bus.data_in_almost_full !== 1'b0) $display("FAIL fill_af11 got %b want 0", bus.data_in_almost_full); else n_pass++;
      end
      if (i == 12) begin
        n_checks++; if (bus.data_in_almost_full !== 1'b1) $display("FAIL fill_af12 got %b want 1", bus.data_in_almost_full); else n_pass++;
      end
      if (i == 15) begin
        n_checks++; if (bus.data_in_full !== 1'b0) $display("FAIL fill_full15 got %b want 0", bus.data_in_full); else n_pass++;
      end
    end
    n_checks++; if (bus.data_in_full !== 1'b1) $display("FAIL fill_full16 got %b want 1", bus.data_in_full); else n_pass++;
    n_checks++; if (bus.level !== 5'd16) $display("FAIL fill_level16 got %0d want 16", bus.level); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL fill_ovf_pre got %b want 0", bus.overflow); else n_pass++;
    cycle(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
    n_checks++; if (bus.level !== 5'd16) $display("FAIL ovf_level got %0d want 16", bus.level); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.data_out !== 32'd1) $display("FAIL ovf_head got %h want 1", bus.data_out); else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      n_checks++; if (bus.data_out !== 32'(i)) $display("FAIL drain_data got %h want %h", bus.data_out, 32'(i)); else n_pass++;
      cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      n_checks++; if (bus.level !== 5'(16 - i)) $display("FAIL drain_level got %0d want %0d", bus.level, 16 - i); else n_pass++;
      n_checks++; if (bus.data_out_almost_empty !== ((16 - i) <= AE)) $display("FAIL drain_ae got %b at level %0d", bus.data_out_almost_empty, 16 - i); else n_pass++;
      if (i < 16) begin
        n_checks++; if (bus.data_out_valid !== 1'b1) $display("FAIL drain_valid got %b want 1", bus.data_out_valid); else n_pass++;
      end
    end
    n_checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL drain_empty_valid got %b want 0", bus.data_out_valid); else n_pass++;
    n_checks++; if (bus.data_out !== 32'h0) $display("FAIL drain_empty_dout got %h want 0", bus.data_out); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL drain_ovf_sticky got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.underflow !== 1'b0) $display("FAIL drain_unf got %b want 0", bus.underflow); else n_pass++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL flush_clears_ovf got %b want 0", bus.overflow); else n_pass++;
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b0, 32'd100, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      n_checks++; if (bus.data_out !== 32'(99 + i)) $display("FAIL b2b_data got %h want %h", bus.data_out, 32'(99 + i)); else n_pass++;
      cycle(1'b1, 1'b1, 32'(100 + i), 1'b0, 1'b0);
      n_checks++; if (bus.level !== 5'd1) $display("FAIL b2b_level got %0d want 1", bus.level); else n_pass++;
    end
    n_checks++; if (bus.data_out !== 32'd140) $display("FAIL b2b_last got %h want %h", bus.data_out, 32'd140); else n_pass++;
    n_checks++; if (bus.underflow !== 1'b0) $display("FAIL b2b_unf got %b want 0", bus.underflow); else n_pass++;
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    n_checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", bus.data_out_valid); else n_pass++;
  endtask

  task automatic test_underflow_push();
    cycle(1'b1, 1'b1, 32'hA5, 1'b0, 1'b0);
    n_checks++; if (bus.underflow !== 1'b1) $display("FAIL unf_flag got %b want 1", bus.underflow); else n_pass++;
    n_checks++; if (bus.level !== 5'd1) $display("FAIL unf_level got %0d want 1", bus.level); else n_pass++;
    n_checks++; if (bus.data_out !== 32'hA5) $display("FAIL unf_dout got %h want a5", bus.data_out); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL unf_ovf got %b want 0", bus.overflow); else n_pass++;
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 32'(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    n_checks++; if (bus.level !== 5'd8) $display("FAIL flush_pre_level got %0d want 8", bus.level); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b11) $display("FAIL flush_pre_flags got %b want 11", {bus.overflow, bus.underflow}); else n_pass++;
    cycle(1'b1, 1'b1, 32'h77, 1'b1, 1'b0);
    n_checks++; if (bus.level !== 5'd0) $display("FAIL flush_level got %0d want 0", bus.level); else n_pass++;
    n_checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.data_out_valid); else n_pass++;
    n_checks++; if (bus.data_out !== 32'h0) $display("FAIL flush_dout got %h want 0", bus.data_out); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL flush_flags got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(300 + i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h99, 1'b0, 1'b1);
    n_checks++; if (bus.level !== 5'd0) $display("FAIL rst_level got %0d want 0", bus.level); else n_pass++;
    n_checks++; if (bus.data_out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.data_out_valid); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL rst_flags got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
    cycle(1'b1, 1'b0, 32'h4242, 1'b0, 1'b0);
    n_checks++; if (bus.data_out !== 32'h4242) $display("FAIL rst_fresh_head got %h want 4242", bus.data_out); else n_pass++;
    n_checks++; if (bus.level !== 5'd1) $display("FAIL rst_fresh_level got %0d want 1", bus.level); else n_pass++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int p_push;
    int p_ack;
    logic v;
    logic a;
    logic f;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_dout;
    int exp_lvl;
    for (int phase = 0; phase < 6; phase++) begin
      p_push = $urandom_range(10, 95);
      p_ack  = $urandom_range(10, 95);
      for (int c = 0; c < 120; c++) begin
        v = ($urandom_range(0, 99) < p_push);
        a = ($urandom_range(0, 99) < p_ack);
        f = ($urandom_range(0, 79) == 0);
        d = $urandom;
        cycle(v, a, d, f, 1'b0);
        exp_lvl  = exp_q.size();
        exp_dout = (exp_lvl != 0) ? exp_q[0] : '0;
        n_checks++; if (bus.level !== 5'(exp_lvl)) $display("FAIL rnd_level got %0d want %0d", bus.level, exp_lvl); else n_pass++;
        n_checks++; if (bus.data_out !== exp_dout) $display("FAIL rnd_dout got %h want %h", bus.data_out, exp_dout); else n_pass++;
        n_checks++; if (bus.data_out_valid !== (exp_lvl != 0)) $display("FAIL rnd_valid got %b want %b", bus.data_out_valid, exp_lvl != 0); else n_pass++;
        n_checks++; if (bus.data_in_full !== (exp_lvl == BS)) $display("FAIL rnd_full got %b want %b", bus.data_in_full, exp_lvl == BS); else n_pass++;
        n_checks++; if (bus.data_in_almost_full !== (exp_lvl >= AF)) $display("FAIL rnd_af got %b want %b", bus.data_in_almost_full, exp_lvl >= AF); else n_pass++;
        n_checks++; if (bus.data_out_almost_empty !== (exp_lvl <= AE)) $display("FAIL rnd_ae got %b want %b", bus.data_out_almost_empty, exp_lvl <= AE); else n_pass++;
        n_checks++; if (bus.overflow !== m_ovf) $display("FAIL rnd_ovf got %b want %b", bus.overflow, m_ovf); else n_pass++;
        n_checks++; if (bus.underflow !== m_unf) $display("FAIL rnd_unf got %b want %b", bus.underflow, m_unf); else n_pass++;
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    flush             = 1'b0;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    bus.data_out_ack  = 1'b0;
    m_ovf             = 0;
    m_unf             = 0;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_back_to_back();
    test_underflow_push();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
